// File: rtl/ftdi_emu_pkg.sv
// Shared types and helpers for the FT245-style FIFO bus emulator.
package ftdi_emu_pkg;

    typedef enum logic [1:0] {
        R_IDLE,
        R_LAT,
        R_DRIVE,
        R_PRE
    } rx_state_t;

    typedef enum logic [1:0] {
        T_IDLE,
        T_ACT,
        T_PRE
    } tx_state_t;

    // Level of rd_n/wr_n when the DUT is not strobing.
    localparam logic STROBE_IDLE = 1'b1;

    function automatic int level_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// Single-clock first-word-fall-through FIFO with occupancy and look-ahead occupancy.
module fifo_sync
    import ftdi_emu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           push,
    input  logic [DATA_W-1:0]              push_data,
    input  logic                           pop,
    output logic [DATA_W-1:0]              head,
    output logic                           full,
    output logic                           empty,
    output logic [level_width(DEPTH)-1:0]  level,
    output logic [level_width(DEPTH)-1:0]  level_next
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LVL_W = level_width(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [LVL_W-1:0]  count;
    logic              do_push;
    logic              do_pop;

    // A push into a full FIFO is only accepted when a pop frees a slot in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign full  = (count == LVL_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];
    assign level = count;

    always_comb begin
        level_next = count;
        if (do_push && !do_pop) begin
            level_next = count + LVL_W'(1);
        end else if (do_pop && !do_push) begin
            level_next = count - LVL_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= level_next;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset && do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/ftdi_fifo_emu.sv
// Emulates the FTDI side of an FT2232H FT245 asynchronous FIFO channel, with host
// valid/ready streams on the other side and an optional DUT-write to DUT-read loopback.
module ftdi_fifo_emu
    import ftdi_emu_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int RX_DEPTH  = 16,
    parameter int TX_DEPTH  = 16,
    parameter int RD_LAT    = 2,
    parameter int PRECHARGE = 2
) (
    input  logic                              in_ext_osc,
    input  logic                              in_reset,
    input  logic                              in_ftdi_rd_n,
    input  logic                              in_ftdi_wr_n,
    input  logic [DATA_W-1:0]                 in_ftdi_data,
    output logic [DATA_W-1:0]                 out_ftdi_data,
    output logic                              out_ftdi_data_oe,
    output logic                              out_ftdi_rxf_n,
    output logic                              out_ftdi_txe_n,
    input  logic                              in_host_tx_valid,
    input  logic [DATA_W-1:0]                 in_host_tx_data,
    output logic                              out_host_tx_ready,
    output logic                              out_host_rx_valid,
    output logic [DATA_W-1:0]                 out_host_rx_data,
    input  logic                              in_host_rx_ready,
    input  logic                              in_loopback,
    output logic [level_width(RX_DEPTH)-1:0]  out_rx_level,
    output logic [level_width(TX_DEPTH)-1:0]  out_tx_level,
    output logic                              out_proto_err
);

    localparam int RX_LW   = level_width(RX_DEPTH);
    localparam int TX_LW   = level_width(TX_DEPTH);
    localparam int CNT_MAX = (RD_LAT > PRECHARGE) ? RD_LAT : PRECHARGE;
    localparam int CNT_W   = level_width(CNT_MAX);
    localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'((RD_LAT > 1) ? RD_LAT - 2 : 0);
    localparam logic [CNT_W-1:0] PRE_LOAD = CNT_W'(PRECHARGE - 1);

    logic              rd_q, rd_prev, wr_q, wr_prev;
    logic              rd_fall, rd_rise, wr_fall, wr_rise;
    logic [DATA_W-1:0] tx_hold;

    rx_state_t         rx_state, rx_next;
    logic [CNT_W-1:0]  rx_cnt, rx_cnt_next;
    tx_state_t         tx_state, tx_next;
    logic [CNT_W-1:0]  tx_cnt, tx_cnt_next;

    logic              rxf_n_q, txe_n_q, proto_err_q;
    logic              loop_mode, loop_mode_next;
    logic              rd_pop, wr_push;
    logic              drive_oe;
    logic [DATA_W-1:0] drive_data;
    logic              dest_full_next;

    logic              rx_push, rx_pop, rx_full, rx_empty;
    logic [DATA_W-1:0] rx_push_data, rx_head;
    logic [RX_LW-1:0]  rx_level, rx_level_next;
    logic              tx_push, tx_pop, tx_full, tx_empty;
    logic [DATA_W-1:0] tx_head;
    logic [TX_LW-1:0]  tx_level, tx_level_next;

    // Strobes are registered once; during reset the history tracks the pin so no edge
    // is seen on release. The write data holds the last value sampled with wr_n low.
    always_ff @(posedge in_ext_osc) begin
        rd_q    <= in_ftdi_rd_n;
        wr_q    <= in_ftdi_wr_n;
        rd_prev <= in_reset ? in_ftdi_rd_n : rd_q;
        wr_prev <= in_reset ? in_ftdi_wr_n : wr_q;
        if (in_reset) begin
            tx_hold <= '0;
        end else if (in_ftdi_wr_n != STROBE_IDLE) begin
            tx_hold <= in_ftdi_data;
        end
    end

    assign rd_fall = rd_prev && !rd_q;
    assign rd_rise = !rd_prev && rd_q;
    assign wr_fall = wr_prev && !wr_q;
    assign wr_rise = !wr_prev && wr_q;

    always_ff @(posedge in_ext_osc) begin
        if (in_reset) begin
            rx_state <= R_IDLE;
            rx_cnt   <= '0;
            tx_state <= T_IDLE;
            tx_cnt   <= '0;
        end else begin
            rx_state <= rx_next;
            rx_cnt   <= rx_cnt_next;
            tx_state <= tx_next;
            tx_cnt   <= tx_cnt_next;
        end
    end

    always_comb begin
        rx_next     = rx_state;
        rx_cnt_next = rx_cnt;
        unique case (rx_state)
            R_IDLE: begin
                if (rd_fall && !rxf_n_q) begin
                    rx_next     = (RD_LAT > 1) ? R_LAT : R_DRIVE;
                    rx_cnt_next = LAT_LOAD;
                end
            end
            R_LAT: begin
                if (rd_rise) begin
                    rx_next     = R_PRE;
                    rx_cnt_next = PRE_LOAD;
                end else if (rx_cnt == '0) begin
                    rx_next = R_DRIVE;
                end else begin
                    rx_cnt_next = rx_cnt - CNT_W'(1);
                end
            end
            R_DRIVE: begin
                if (rd_rise) begin
                    rx_next     = R_PRE;
                    rx_cnt_next = PRE_LOAD;
                end
            end
            R_PRE: begin
                if (rx_cnt == '0) begin
                    rx_next = R_IDLE;
                end else begin
                    rx_cnt_next = rx_cnt - CNT_W'(1);
                end
            end
            default: rx_next = R_IDLE;
        endcase
    end

    always_comb begin
        drive_oe   = (rx_state == R_LAT) || (rx_state == R_DRIVE);
        drive_data = (rx_state == R_DRIVE) ? rx_head : '0;
        rd_pop     = drive_oe && rd_rise;
    end

    always_comb begin
        tx_next     = tx_state;
        tx_cnt_next = tx_cnt;
        unique case (tx_state)
            T_IDLE: begin
                if (wr_fall && !txe_n_q) begin
                    tx_next = T_ACT;
                end
            end
            T_ACT: begin
                if (wr_rise) begin
                    tx_next     = T_PRE;
                    tx_cnt_next = PRE_LOAD;
                end
            end
            T_PRE: begin
                if (tx_cnt == '0) begin
                    tx_next = T_IDLE;
                end else begin
                    tx_cnt_next = tx_cnt - CNT_W'(1);
                end
            end
            default: tx_next = T_IDLE;
        endcase
    end

    always_comb begin
        wr_push = (tx_state == T_ACT) && wr_rise;
    end

    // Loop mode only follows the request while both sides are idle.
    assign loop_mode_next = (rx_state == R_IDLE && tx_state == T_IDLE) ? in_loopback : loop_mode;
    assign dest_full_next = loop_mode_next ? (rx_level_next == RX_LW'(RX_DEPTH))
                                           : (tx_level_next == TX_LW'(TX_DEPTH));

    // rxf_n/txe_n are computed from next state and next occupancy so the flops line up
    // with the FSM states they describe.
    always_ff @(posedge in_ext_osc) begin
        if (in_reset) begin
            rxf_n_q     <= 1'b1;
            txe_n_q     <= 1'b1;
            proto_err_q <= 1'b0;
            loop_mode   <= 1'b0;
        end else begin
            rxf_n_q     <= !(rx_next == R_IDLE && rx_level_next != '0);
            txe_n_q     <= !(tx_next == T_IDLE && !dest_full_next);
            proto_err_q <= proto_err_q || (rd_fall && rxf_n_q) || (wr_fall && txe_n_q);
            loop_mode   <= loop_mode_next;
        end
    end

    assign out_host_tx_ready = !rx_full && !loop_mode && !in_reset;
    assign rx_push           = loop_mode ? wr_push : (in_host_tx_valid && out_host_tx_ready);
    assign rx_push_data      = loop_mode ? tx_hold : in_host_tx_data;
    assign rx_pop            = rd_pop && !rx_empty;
    assign tx_push           = wr_push && !loop_mode && !tx_full;
    assign tx_pop            = !tx_empty && in_host_rx_ready;

    fifo_sync #(
        .DATA_W (DATA_W),
        .DEPTH  (RX_DEPTH)
    ) u_rx_fifo (
        .clock      (in_ext_osc),
        .reset      (in_reset),
        .push       (rx_push),
        .push_data  (rx_push_data),
        .pop        (rx_pop),
        .head       (rx_head),
        .full       (rx_full),
        .empty      (rx_empty),
        .level      (rx_level),
        .level_next (rx_level_next)
    );

    fifo_sync #(
        .DATA_W (DATA_W),
        .DEPTH  (TX_DEPTH)
    ) u_tx_fifo (
        .clock      (in_ext_osc),
        .reset      (in_reset),
        .push       (tx_push),
        .push_data  (tx_hold),
        .pop        (tx_pop),
        .head       (tx_head),
        .full       (tx_full),
        .empty      (tx_empty),
        .level      (tx_level),
        .level_next (tx_level_next)
    );

    assign out_ftdi_data     = drive_data;
    assign out_ftdi_data_oe  = drive_oe;
    assign out_ftdi_rxf_n    = rxf_n_q;
    assign out_ftdi_txe_n    = txe_n_q;
    assign out_host_rx_valid = !tx_empty;
    assign out_host_rx_data  = tx_head;
    assign out_rx_level      = rx_level;
    assign out_tx_level      = tx_level;
    assign out_proto_err     = proto_err_q;

endmodule
